// File: rtl/i3c_pkg.sv
// Shared types and helpers for the SDR I3C controller.
package i3c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WDATA,
        ST_WPAR,
        ST_RDATA,
        ST_RTBIT,
        ST_STOP,
        ST_DONE
    } ctrl_state_t;

    localparam logic [6:0] I3C_BCAST_ADDR = 7'h7E;

    // T-bit for a written byte: odd parity over data plus T
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/i3c_scl_tick_gen.sv
// Quarter-period tick generator for the SCL bit engine.
module i3c_scl_tick_gen #(
    parameter logic [7:0] CLK_DIV = 8'd4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic freeze,
    output logic tick
);

    localparam logic [7:0] LAST = CLK_DIV - 8'd1;

    logic [7:0] cnt;

    // Divider counter; held at zero while cleared, paused while frozen
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt <= '0;
        end else if (!freeze) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 8'd1;
        end
    end

    assign tick = (cnt == LAST) && !freeze;

endmodule

// File: rtl/i3c_master_sdr_ctrl.sv
// SDR I3C controller: private read/write transfers with START, address,
// ACK check, data bytes with T-bits, and STOP.
module i3c_master_sdr_ctrl
    import i3c_pkg::*;
#(
    parameter logic [7:0] CLK_DIV = 8'd4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rnw,
    input  logic [3:0] cmd_len,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       done,
    output logic       nack_err,
    output logic       early_end,
    output logic       busy,
    output logic       scl_out,
    output logic       sda_oe,
    input  logic       sda_in
);

    ctrl_state_t state;
    logic [1:0]  q;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic [6:0]  addr_q;
    logic        rnw_q;
    logic [3:0]  len_q;
    logic [3:0]  cnt;
    logic        par_q;
    logic        smp_q;
    logic        tick;
    logic        stall;

    // Waiting for a write byte at the first quarter of its MSB
    assign stall = (state == ST_WDATA) && (q == 2'd0) && (bit_idx == 3'd7) && !tx_valid;

    i3c_scl_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state == ST_IDLE),
        .freeze(stall),
        .tick  (tick)
    );

    // Controller FSM: every bit-level action happens on a quarter tick
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            q         <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            addr_q    <= '0;
            rnw_q     <= 1'b0;
            len_q     <= '0;
            cnt       <= '0;
            par_q     <= 1'b0;
            smp_q     <= 1'b0;
            scl_out   <= 1'b1;
            sda_oe    <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            tx_ready  <= 1'b0;
            rx_valid  <= 1'b0;
            rx_data   <= '0;
            done      <= 1'b0;
            nack_err  <= 1'b0;
            early_end <= 1'b0;
        end else begin
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            done     <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        addr_q    <= cmd_addr;
                        rnw_q     <= cmd_rnw;
                        len_q     <= cmd_len;
                        cnt       <= '0;
                        q         <= '0;
                        nack_err  <= 1'b0;
                        early_end <= 1'b0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_START;
                    end
                end
                ST_DONE: begin
                    done      <= 1'b1;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    if (tick) begin
                        q <= q + 2'd1;
                        case (q)
                            2'd0: begin
                                case (state)
                                    ST_START, ST_STOP: sda_oe <= 1'b1;
                                    ST_ADDR:           sda_oe <= ~shreg[7];
                                    ST_ADDR_ACK,
                                    ST_RDATA:          sda_oe <= 1'b0;
                                    ST_WDATA: begin
                                        if (bit_idx == 3'd7) begin
                                            shreg    <= tx_data;
                                            par_q    <= odd_parity(tx_data);
                                            tx_ready <= 1'b1;
                                            sda_oe   <= ~tx_data[7];
                                        end else begin
                                            sda_oe <= ~shreg[7];
                                        end
                                    end
                                    ST_WPAR:  sda_oe <= ~par_q;
                                    // Last byte: hold SDA low so the target cannot continue
                                    ST_RTBIT: sda_oe <= (cnt == len_q);
                                    default: ;
                                endcase
                            end
                            // START drops SCL here; every other phase raises it
                            2'd1: scl_out <= (state != ST_START);
                            2'd2: begin
                                case (state)
                                    ST_ADDR_ACK, ST_RTBIT: smp_q <= sda_in;
                                    ST_RDATA: shreg  <= {shreg[6:0], sda_in};
                                    ST_STOP:  sda_oe <= 1'b0;
                                    default: ;
                                endcase
                            end
                            default: begin
                                if (state != ST_STOP) begin
                                    scl_out <= 1'b0;
                                end
                                case (state)
                                    ST_START: begin
                                        shreg   <= {addr_q, rnw_q};
                                        bit_idx <= 3'd7;
                                        state   <= ST_ADDR;
                                    end
                                    ST_ADDR, ST_WDATA: begin
                                        if (bit_idx == 3'd0) begin
                                            state <= (state == ST_ADDR) ? ST_ADDR_ACK : ST_WPAR;
                                        end else begin
                                            bit_idx <= bit_idx - 3'd1;
                                            shreg   <= {shreg[6:0], 1'b0};
                                        end
                                    end
                                    ST_ADDR_ACK: begin
                                        if (smp_q) begin
                                            nack_err <= 1'b1;
                                            state    <= ST_STOP;
                                        end else if (len_q == 4'd0) begin
                                            state <= ST_STOP;
                                        end else begin
                                            bit_idx <= 3'd7;
                                            state   <= rnw_q ? ST_RDATA : ST_WDATA;
                                        end
                                    end
                                    ST_WPAR: begin
                                        cnt <= cnt + 4'd1;
                                        if (cnt + 4'd1 == len_q) begin
                                            state <= ST_STOP;
                                        end else begin
                                            bit_idx <= 3'd7;
                                            state   <= ST_WDATA;
                                        end
                                    end
                                    ST_RDATA: begin
                                        if (bit_idx == 3'd0) begin
                                            rx_data  <= shreg;
                                            rx_valid <= 1'b1;
                                            cnt      <= cnt + 4'd1;
                                            state    <= ST_RTBIT;
                                        end else begin
                                            bit_idx <= bit_idx - 3'd1;
                                        end
                                    end
                                    ST_RTBIT: begin
                                        if (cnt == len_q) begin
                                            state <= ST_STOP;
                                        end else if (!smp_q) begin
                                            early_end <= 1'b1;
                                            state     <= ST_STOP;
                                        end else begin
                                            bit_idx <= 3'd7;
                                            state   <= ST_RDATA;
                                        end
                                    end
                                    ST_STOP: state <= ST_DONE;
                                    default: ;
                                endcase
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i3c_master_sdr_ctrl.sv
// Self-checking bench for i3c_master_sdr_ctrl with a behavioural I3C target.
`timescale 1ns/1ps
module tb_i3c_master_sdr_ctrl;
    import i3c_pkg::*;

    localparam logic [7:0] D = 8'd4;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_addr;
    logic       cmd_rnw;
    logic [3:0] cmd_len;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       done;
    logic       nack_err;
    logic       early_end;
    logic       busy;
    logic       scl_out;
    logic       sda_oe;
    logic       sda_in;
    logic       tgt_sda;

    i3c_master_sdr_ctrl #(
        .CLK_DIV(D)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr (cmd_addr),
        .cmd_rnw  (cmd_rnw),
        .cmd_len  (cmd_len),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .done     (done),
        .nack_err (nack_err),
        .early_end(early_end),
        .busy     (busy),
        .scl_out  (scl_out),
        .sda_oe   (sda_oe),
        .sda_in   (sda_in)
    );

    // Open-drain bus: either side can pull low
    assign sda_in = sda_oe ? 1'b0 : tgt_sda;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]      addr;
        logic            rnw;
        logic [3:0]      len;
        logic            ack;
        logic [3:0][7:0] data;
        int unsigned     t0;
        logic            exp_nack;
        logic            exp_early;
        int unsigned     exp_n;
    } vec_t;

    int          total;
    int          bad;
    logic        exp_bits[$];
    logic [7:0]  exp_rx[$];
    logic [7:0]  txq[$];
    logic        cfg_ack;
    logic        cfg_rnw;
    logic [3:0][7:0] cfg_data;
    int unsigned cfg_t0;
    int unsigned fall_cnt;
    int unsigned rise_cnt;
    int unsigned n_txr;
    int unsigned n_rxv;
    bit          chk_en;
    bit          hold_tx;
    logic        scl_q;
    logic        oe_q;
    vec_t        vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Target response for the bit slot following START (slot 8 is the address ACK)
    function automatic logic slot_val(input int unsigned s);
        int unsigned j;
        int unsigned b;
        if (s < 8) return 1'b1;
        if (s == 8) return cfg_ack;
        if (!cfg_rnw) return 1'b1;
        j = (s - 9) / 9;
        b = (s - 9) % 9;
        if (j >= 4) return 1'b1;
        if (b < 8) return cfg_data[j][7 - b];
        return (cfg_t0 == j + 1) ? 1'b0 : 1'b1;
    endfunction

    // Target model, bus monitor and write-data source
    initial begin
        scl_q    = 1'b1;
        oe_q     = 1'b0;
        tgt_sda  = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                fall_cnt = 0;
                rise_cnt = 0;
                tgt_sda  = 1'b1;
            end else begin
                if (sda_oe && !oe_q && scl_out) begin
                    fall_cnt = 0;
                    rise_cnt = 0;
                    tgt_sda  = 1'b1;
                end
                if (scl_out && !scl_q) begin
                    rise_cnt++;
                    if (chk_en) begin
                        if (exp_bits.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL extra_bit: got %b required none", sda_in);
                        end else begin
                            check("bus_bit", 32'(sda_in), 32'(exp_bits.pop_front()));
                        end
                    end
                end
                if (!scl_out && scl_q) begin
                    fall_cnt++;
                    tgt_sda = slot_val(fall_cnt - 1);
                end
                if (rx_valid) begin
                    n_rxv++;
                    if (chk_en) begin
                        if (exp_rx.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL extra_rx: got %0h required none", rx_data);
                        end else begin
                            check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
                        end
                    end
                end
                if (tx_ready) begin
                    n_txr++;
                    if (txq.size() > 0) void'(txq.pop_front());
                end
            end
            scl_q    = scl_out;
            oe_q     = sda_oe;
            tx_valid = (txq.size() > 0) && !hold_tx;
            tx_data  = (txq.size() > 0) ? txq[0] : 8'h00;
        end
    end

    task automatic run_vec(input vec_t v, input int unsigned stall);
        int unsigned cycles;
        int unsigned ones;
        logic [7:0]  dj;
        bit          stop_model;
        bit          high_seen;
        stop_model = 1'b0;
        for (int i = 6; i >= 0; i--) exp_bits.push_back(v.addr[i]);
        exp_bits.push_back(v.rnw);
        exp_bits.push_back(v.ack);
        if (!v.ack) begin
            for (int unsigned j = 0; j < 32'(v.len) && !stop_model; j++) begin
                dj = v.data[j];
                for (int b = 7; b >= 0; b--) exp_bits.push_back(dj[b]);
                if (!v.rnw) begin
                    ones = 0;
                    for (int b = 0; b < 8; b++) ones += 32'(dj[b]);
                    exp_bits.push_back(ones % 2 == 0);
                    txq.push_back(dj);
                end else begin
                    exp_rx.push_back(dj);
                    if (j == 32'(v.len) - 1) begin
                        exp_bits.push_back(1'b0);
                    end else if (v.t0 == j + 1) begin
                        exp_bits.push_back(1'b0);
                        stop_model = 1'b1;
                    end else begin
                        exp_bits.push_back(1'b1);
                    end
                end
            end
        end
        exp_bits.push_back(1'b0);

        cfg_ack  = v.ack;
        cfg_rnw  = v.rnw;
        cfg_data = v.data;
        cfg_t0   = v.t0;
        hold_tx  = (stall != 0);
        n_txr    = 0;
        n_rxv    = 0;
        fall_cnt = 0;
        rise_cnt = 0;

        @(negedge clk);
        cmd_addr  = v.addr;
        cmd_rnw   = v.rnw;
        cmd_len   = v.len;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("busy_after_accept", 32'(busy), 1);
        check("cmd_ready_busy", 32'(cmd_ready), 0);
        cycles = 0;

        if (stall != 0) begin
            while (fall_cnt < 10 && cycles < 5000) begin
                @(negedge clk);
                cycles++;
            end
            check("stall_reached", 32'(fall_cnt >= 10), 1);
            high_seen = 1'b0;
            repeat (stall) begin
                @(negedge clk);
                cycles++;
                if (scl_out) high_seen = 1'b1;
            end
            check("stall_scl_high", 32'(high_seen), 0);
            check("stall_tx_ready", n_txr, 0);
            hold_tx = 1'b0;
        end

        while (!done && cycles < 20000) begin
            @(negedge clk);
            cycles++;
        end
        check("done_seen", 32'(done), 1);
        if (done) begin
            check("nack_err", 32'(nack_err), 32'(v.exp_nack));
            check("early_end", 32'(early_end), 32'(v.exp_early));
            if (stall == 0) check("latency", cycles, (11 + 9 * v.exp_n) * 4 * 32'(D) + 1);
        end
        check("tx_ready_count", n_txr, v.rnw ? 32'd0 : v.exp_n);
        check("rx_valid_count", n_rxv, v.rnw ? v.exp_n : 32'd0);
        check("bits_left", exp_bits.size(), 0);
        check("rx_left", exp_rx.size(), 0);
        repeat (2) @(negedge clk);
        check("done_width", 32'(done), 0);
        check("nack_hold", 32'(nack_err), 32'(v.exp_nack));
        check("idle_ready", 32'(cmd_ready), 1);
        txq.delete();
        exp_bits.delete();
        exp_rx.delete();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        int unsigned n;
        total     = 0;
        bad       = 0;
        chk_en    = 1'b1;
        hold_tx   = 1'b0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_rnw   = 1'b0;
        cmd_len   = '0;
        cfg_ack   = 1'b0;
        cfg_rnw   = 1'b0;
        cfg_data  = '0;
        cfg_t0    = 0;

        //            addr            rnw  len  ack  data          t0 nack early n
        vecs[0] = '{7'h50,          1'b0, 4'd2, 1'b0, 32'h00003CA5, 0, 1'b0, 1'b0, 2};
        vecs[1] = '{7'h2A,          1'b1, 4'd3, 1'b0, 32'h00332211, 0, 1'b0, 1'b0, 3};
        vecs[2] = '{7'h2A,          1'b1, 4'd4, 1'b0, 32'h77665544, 2, 1'b0, 1'b1, 2};
        vecs[3] = '{7'h13,          1'b0, 4'd1, 1'b1, 32'h000000AA, 0, 1'b1, 1'b0, 0};
        vecs[4] = '{I3C_BCAST_ADDR, 1'b0, 4'd0, 1'b0, 32'h00000000, 0, 1'b0, 1'b0, 0};
        vecs[5] = '{I3C_BCAST_ADDR, 1'b0, 4'd3, 1'b0, 32'h0000FF07, 0, 1'b0, 1'b0, 3};
        vecs[6] = '{7'h55,          1'b1, 4'd1, 1'b1, 32'h00000000, 0, 1'b1, 1'b0, 0};
        vecs[7] = '{7'h01,          1'b1, 4'd2, 1'b0, 32'h00007F80, 0, 1'b0, 1'b0, 2};

        repeat (3) @(negedge clk);
        check("rst_scl", 32'(scl_out), 1);
        check("rst_sda_oe", 32'(sda_oe), 0);
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_pulses", {29'd0, done, rx_valid, tx_ready}, 0);
        check("rst_flags", {30'd0, nack_err, early_end}, 0);
        check("rst_rx_data", 32'(rx_data), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_scl", 32'(scl_out), 1);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], 0);

        // Write whose first byte arrives 50 cycles late
        rv = '{7'h33, 1'b0, 4'd2, 1'b0, 32'h0000C381, 0, 1'b0, 1'b0, 2};
        run_vec(rv, 50);

        // Reset in the middle of a read data byte (bit 4)
        chk_en   = 1'b0;
        cfg_ack  = 1'b0;
        cfg_rnw  = 1'b1;
        cfg_data = 32'h00005A6B;
        cfg_t0   = 0;
        rise_cnt = 0;
        @(negedge clk);
        cmd_addr  = 7'h2A;
        cmd_rnw   = 1'b1;
        cmd_len   = 4'd2;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (rise_cnt < 13 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("rst_point_reached", 32'(rise_cnt >= 13), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_scl", 32'(scl_out), 1);
        check("midrst_sda_oe", 32'(sda_oe), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_cmd_ready", 32'(cmd_ready), 1);
        check("midrst_rx_data", 32'(rx_data), 0);
        rst_n = 1'b1;
        exp_bits.delete();
        exp_rx.delete();
        txq.delete();
        @(negedge clk);
        chk_en = 1'b1;
        run_vec(vecs[0], 0);
        run_vec(vecs[1], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
